// File: rtl/ibis_tmds_encoder_if.sv
// Symbol-level bus between a TMDS source and ibis_tmds_encoder: one input symbol and its mode in, one 10-bit word out.
// The master drives the symbol and the encoder (slave) returns the encoded word with a one-cycle valid pulse.
interface ibis_tmds_encoder_if;
    logic       in_valid;
    logic [1:0] in_mode;
    logic [7:0] in_data;
    logic [1:0] in_ctrl;
    logic [3:0] in_terc4;
    logic [9:0] out_parallel;
    logic       out_valid;

    modport master (
        output in_valid, in_mode, in_data, in_ctrl, in_terc4,
        input  out_parallel, out_valid
    );

    modport slave (
        input  in_valid, in_mode, in_data, in_ctrl, in_terc4,
        output out_parallel, out_valid
    );
endinterface

// File: rtl/ibis_tmds_encoder.sv
// TMDS 8b/10b encoder: DVI video, control codes, and HDMI TERC4 only when IBIS_TMDS_TERC4_EN is defined.
// Latency 2 enabled cycles (q_m stage, disparity stage); no backpressure, enable=0 freezes the whole pipeline.
module ibis_tmds_encoder (
    input  logic               aclk,
    input  logic               areset,
    input  logic               enable,
    ibis_tmds_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        SYM_VIDEO = 2'd0,
        SYM_CTRL  = 2'd1,
        SYM_TERC4 = 2'd2
    } sym_kind_t;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = CTRL_00;
            2'b01:   code = CTRL_01;
            2'b10:   code = CTRL_10;
            default: code = CTRL_11;
        endcase
        return code;
    endfunction

`ifdef IBIS_TMDS_TERC4_EN
    function automatic logic [9:0] terc4_code(input logic [3:0] t);
        logic [9:0] code;
        case (t)
            4'h0:    code = 10'b1010011100;
            4'h1:    code = 10'b1001100011;
            4'h2:    code = 10'b1011100100;
            4'h3:    code = 10'b1011100010;
            4'h4:    code = 10'b0101110001;
            4'h5:    code = 10'b0100011110;
            4'h6:    code = 10'b0110001110;
            4'h7:    code = 10'b0100111100;
            4'h8:    code = 10'b1011001100;
            4'h9:    code = 10'b0100111001;
            4'hA:    code = 10'b0110011100;
            4'hB:    code = 10'b1011000110;
            4'hC:    code = 10'b1010001110;
            4'hD:    code = 10'b1001110001;
            4'hE:    code = 10'b0101100011;
            default: code = 10'b1011000011;
        endcase
        return code;
    endfunction
`endif

    // ---------------- stage 1: transition minimisation ----------------
    logic [3:0] din_ones;
    logic       use_xnor;
    logic [8:0] qm_d;
    logic [3:0] qm_ones_d;
    sym_kind_t  kind_d;

    always_comb begin
        din_ones = '0;
        for (int i = 0; i < 8; i++) begin
            din_ones = din_ones + {3'b000, bus.in_data[i]};
        end
        use_xnor = (din_ones > 4'd4) || ((din_ones == 4'd4) && !bus.in_data[0]);

        qm_d    = '0;
        qm_d[0] = bus.in_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ bus.in_data[i]) : (qm_d[i-1] ^ bus.in_data[i]);
        end
        qm_d[8] = ~use_xnor;

        qm_ones_d = '0;
        for (int i = 0; i < 8; i++) begin
            qm_ones_d = qm_ones_d + {3'b000, qm_d[i]};
        end
    end

    // Reserved mode 11 (and 10 when TERC4 is compiled out) falls back to control.
    always_comb begin
        kind_d = SYM_CTRL;
        if (bus.in_mode == 2'b00) begin
            kind_d = SYM_VIDEO;
        end
`ifdef IBIS_TMDS_TERC4_EN
        else if (bus.in_mode == 2'b10) begin
            kind_d = SYM_TERC4;
        end
`endif
    end

    logic       s1_vld_q;
    sym_kind_t  kind_q;
    logic [8:0] qm_q;
    logic [3:0] n1_q;
    logic [3:0] n0_q;
    logic [1:0] ctrl_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_vld_q <= 1'b0;
            kind_q   <= SYM_CTRL;
            qm_q     <= '0;
            n1_q     <= '0;
            n0_q     <= '0;
            ctrl_q   <= '0;
        end else if (enable) begin
            s1_vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                kind_q <= kind_d;
                qm_q   <= qm_d;
                n1_q   <= qm_ones_d;
                n0_q   <= 4'd8 - qm_ones_d;
                ctrl_q <= bus.in_ctrl;
            end
        end
    end

`ifdef IBIS_TMDS_TERC4_EN
    logic [3:0] terc4_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            terc4_q <= '0;
        end else if (enable && bus.in_valid) begin
            terc4_q <= bus.in_terc4;
        end
    end
`else
    logic unused_terc4;
    assign unused_terc4 = ^bus.in_terc4;
`endif

    // ---------------- stage 2: DC balance ----------------
    logic [9:0]        out_q;
    logic [9:0]        out_d;
    logic              out_vld_q;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;
    logic signed [4:0] n1_s;
    logic signed [4:0] n0_s;

    // cnt stays within +/-10, so 5-bit two's complement arithmetic never wraps.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        n1_s  = $signed({1'b0, n1_q});
        n0_s  = $signed({1'b0, n0_q});
        case (kind_q)
            SYM_VIDEO: begin
                if ((cnt_q == 5'sd0) || (n1_q == n0_q)) begin
                    out_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d = qm_q[8] ? (cnt_q + n1_s - n0_s) : (cnt_q + n0_s - n1_s);
                end else if ((!cnt_q[4] && (n1_q > n0_q)) || (cnt_q[4] && (n0_q > n1_q))) begin
                    out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) + n0_s - n1_s;
                end else begin
                    out_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + n1_s - n0_s;
                end
            end
`ifdef IBIS_TMDS_TERC4_EN
            SYM_TERC4: begin
                out_d = terc4_code(terc4_q);
                cnt_d = '0;
            end
`endif
            default: begin
                out_d = ctrl_code(ctrl_q);
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_q     <= CTRL_00;
            out_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else if (enable) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_q <= out_d;
                cnt_q <= cnt_d;
            end
        end else begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.out_parallel = out_q;
    assign bus.out_valid    = out_vld_q;

endmodule

// File: tb/tb_ibis_tmds_encoder.sv
// Directed and random-video checks of ibis_tmds_encoder against a behavioural DVI/TMDS reference.
module tb_ibis_tmds_encoder;

    logic aclk = 1'b0;
    logic areset;
    logic enable;

    ibis_tmds_encoder_if bus ();

    ibis_tmds_encoder dut (
        .aclk   (aclk),
        .areset (areset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         mcnt     = 0;
    logic [9:0] exp_w_q[$];
    int         exp_c_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = 10'b1101010100;
            2'b01:   w = 10'b0010101011;
            2'b10:   w = 10'b0101010100;
            default: w = 10'b1010101011;
        endcase
        return w;
    endfunction

    // Behavioural DVI 1.0 encoder; mcnt is the reference running disparity.
    function automatic logic [9:0] ref_enc(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c);
        logic [8:0] qm;
        logic [9:0] w;
        logic       xn;
        int         ones;
        int         n1;
        int         n0;
        if (m != 2'b00) begin
            mcnt = 0;
            return ref_ctrl(c);
        end
        ones  = $countones(d);
        xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (mcnt == 0 || n1 == n0) begin
            w    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt = mcnt + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            w    = {1'b1, qm[8], ~qm[7:0]};
            mcnt = mcnt + (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            w    = {1'b0, qm[8], qm[7:0]};
            mcnt = mcnt - (qm[8] ? 0 : 2) + n1 - n0;
        end
        return w;
    endfunction

    task automatic drv(input logic en, input logic vld, input logic [1:0] m,
                       input logic [7:0] d, input logic [1:0] c, input logic [3:0] t);
        enable       = en;
        bus.in_valid = vld;
        bus.in_mode  = m;
        bus.in_data  = d;
        bus.in_ctrl  = c;
        bus.in_terc4 = t;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic monitor();
        if (bus.out_valid) begin
            if (exp_w_q.size() == 0) begin
                chk("rnd_spurious_vld", 1, 0);
            end else begin
                chk("rnd_out", int'(bus.out_parallel), int'(exp_w_q.pop_front()));
                chk("rnd_cnt", int'(dut.cnt_q), exp_c_q.pop_front());
                chk("rnd_cnt_range", int'(int'(dut.cnt_q) >= -10 && int'(dut.cnt_q) <= 10), 1);
            end
        end
    endtask

    task automatic push_exp(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c);
        exp_w_q.push_back(ref_enc(m, d, c));
        exp_c_q.push_back(mcnt);
    endtask

    initial begin
        logic       en_r;
        logic       vld_r;
        logic [1:0] m_r;
        logic [7:0] d_r;
        logic [1:0] c_r;
        int         accepted;
        int         cyc;
        int         terc_exp;

        // Reset, asserted with enable low.
        drv(1'b0, 1'b1, 2'b00, 8'hAA, 2'b11, 4'h0);
        areset = 1'b1;
        repeat (3) step();
        chk("rst_out", int'(bus.out_parallel), 10'h354);
        chk("rst_vld", int'(bus.out_valid), 0);
        chk("rst_cnt", int'(dut.cnt_q), 0);
        areset = 1'b0;

        // Video 0x00 twice back-to-back.
        drv(1'b1, 1'b1, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("v00_first_edge_vld", int'(bus.out_valid), 0);
        step();
        chk("v00_a_out", int'(bus.out_parallel), 10'h100);
        chk("v00_a_vld", int'(bus.out_valid), 1);
        chk("v00_a_cnt", int'(dut.cnt_q), -8);
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("v00_b_out", int'(bus.out_parallel), 10'h3FF);
        chk("v00_b_vld", int'(bus.out_valid), 1);
        chk("v00_b_cnt", int'(dut.cnt_q), 2);
        step();
        chk("idle_vld", int'(bus.out_valid), 0);
        chk("idle_hold", int'(bus.out_parallel), 10'h3FF);

        // Control 01 with cnt=+2, then video 0x00 must restart from cnt=0.
        drv(1'b1, 1'b1, 2'b01, 8'h00, 2'b01, 4'h0);
        step();
        drv(1'b1, 1'b1, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("ctrl01_out", int'(bus.out_parallel), 10'h0AB);
        chk("ctrl01_cnt", int'(dut.cnt_q), 0);
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("post_ctrl_out", int'(bus.out_parallel), 10'h100);
        chk("post_ctrl_cnt", int'(dut.cnt_q), -8);

        // Mode 10 (TERC4 or control), reserved mode 11, control 11.
`ifdef IBIS_TMDS_TERC4_EN
        terc_exp = 10'h29C;
`else
        terc_exp = 10'h354;
`endif
        drv(1'b1, 1'b1, 2'b10, 8'h00, 2'b00, 4'h0);
        step();
        drv(1'b1, 1'b1, 2'b11, 8'h00, 2'b10, 4'h0);
        step();
        chk("mode10_out", int'(bus.out_parallel), terc_exp);
        chk("mode10_cnt", int'(dut.cnt_q), 0);
        drv(1'b1, 1'b1, 2'b01, 8'h00, 2'b11, 4'h0);
        step();
        chk("mode11_out", int'(bus.out_parallel), 10'h154);
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("ctrl11_out", int'(bus.out_parallel), 10'h2AB);

        // Accept 0xFF, freeze three cycles (with a valid symbol offered), then resume.
        drv(1'b1, 1'b1, 2'b00, 8'hFF, 2'b00, 4'h0);
        step();
        drv(1'b0, 1'b1, 2'b00, 8'h00, 2'b00, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_vld", int'(bus.out_valid), 0);
            chk("hold_out", int'(bus.out_parallel), 10'h2AB);
        end
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("resume_out", int'(bus.out_parallel), 10'h200);
        chk("resume_vld", int'(bus.out_valid), 1);
        chk("resume_cnt", int'(dut.cnt_q), -8);
        step();
        chk("resume_pulse", int'(bus.out_valid), 0);

        // Popcount-4 tie-break: 0x1E takes XNOR, 0x0F takes XOR.
        drv(1'b1, 1'b1, 2'b00, 8'h1E, 2'b00, 4'h0);
        step();
        drv(1'b1, 1'b1, 2'b00, 8'h0F, 2'b00, 4'h0);
        step();
        chk("tie_1e_out", int'(bus.out_parallel), 10'h25F);
        chk("tie_1e_cnt", int'(dut.cnt_q), -4);
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("tie_0f_out", int'(bus.out_parallel), 10'h3FA);
        chk("tie_0f_cnt", int'(dut.cnt_q), 2);

        // Random stream against the reference, with enable and valid gaps.
        areset = 1'b1;
        step();
        areset = 1'b0;
        mcnt = 0;
        exp_w_q.delete();
        exp_c_q.delete();
        accepted = 0;
        cyc      = 0;
        while (accepted < 10000 && cyc < 40000) begin
            en_r  = ($urandom_range(0, 9) != 0);
            vld_r = ($urandom_range(0, 4) != 0);
            m_r   = ($urandom_range(0, 15) != 0) ? 2'b00 : (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11);
            d_r   = 8'($urandom);
            c_r   = 2'($urandom);
            drv(en_r, vld_r, m_r, d_r, c_r, 4'($urandom));
            if (en_r && vld_r) begin
                push_exp(m_r, d_r, c_r);
                accepted++;
            end
            step();
            cyc++;
            monitor();
        end
        chk("rnd_accepted", accepted, 10000);
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        repeat (3) begin
            step();
            monitor();
        end
        chk("rnd_drain", exp_w_q.size(), 0);

        // Reset with symbols in flight.
        drv(1'b1, 1'b1, 2'b00, 8'h5A, 2'b00, 4'h0);
        push_exp(2'b00, 8'h5A, 2'b00);
        step();
        monitor();
        drv(1'b1, 1'b1, 2'b00, 8'hC3, 2'b00, 4'h0);
        push_exp(2'b00, 8'hC3, 2'b00);
        step();
        monitor();
        areset = 1'b1;
        drv(1'b0, 1'b1, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("mid_rst_out", int'(bus.out_parallel), 10'h354);
        chk("mid_rst_vld", int'(bus.out_valid), 0);
        chk("mid_rst_cnt", int'(dut.cnt_q), 0);
        areset = 1'b0;
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_vld", int'(bus.out_valid), 0);
            chk("post_rst_out", int'(bus.out_parallel), 10'h354);
        end
        drv(1'b1, 1'b1, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("post_rst_first_vld", int'(bus.out_valid), 0);
        drv(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 4'h0);
        step();
        chk("post_rst_sym_out", int'(bus.out_parallel), 10'h100);
        chk("post_rst_sym_vld", int'(bus.out_valid), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ibis_tmds_encoder.md
IBIS_TMDS_ENCODER -- requirements
Module: ibis_tmds_encoder

Interface
REQ-001 SHALL have port aclk, input, 1, sole clock; all logic rising-edge.
REQ-002 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port enable, input, 1, global clock enable; low = full pipeline hold.
REQ-004 SHALL have port in_valid, input, 1, input symbol qualifier.
REQ-005 SHALL have port in_mode, input, 2, period select: 00 video, 01 control, 10 TERC4, 11 reserved.
REQ-006 SHALL have port in_data, input, 8, video byte.
REQ-007 SHALL have port in_ctrl, input, 2, control bits {C1,C0}.
REQ-008 SHALL have port in_terc4, input, 4, data-island nibble.
REQ-009 SHALL have port out_parallel, output, 10, encoded symbol for the downstream 10:1 serializer; bit 0 transmitted first.
REQ-010 SHALL have port out_valid, output, 1, one-cycle pulse when out_parallel updates.

Function
REQ-011 SHALL register a symbol only on a cycle with enable=1 and in_valid=1; other cycles leave pipeline contents unchanged.
REQ-012 SHALL be a 2-stage pipeline: stage 1 registers q_m[8:0] plus n1/n0 counts of q_m[7:0]; stage 2 registers out_parallel and updates disparity.
REQ-013 SHALL update out_parallel exactly 2 enabled cycles after acceptance; out_valid high that cycle only.
REQ-014 SHALL hold out_parallel between updates, so a consumer sampling every 5th cycle always sees a stable symbol.
REQ-015 SHALL, in video mode, build q_m by XNOR chain if popcount(in_data)>4 or (=4 and in_data[0]=0), else XOR chain; q_m[8]=1 for XOR, 0 for XNOR.
REQ-016 SHALL keep running disparity cnt as a 5-bit signed register, DVI 1.0 rules: cnt=0 or n1=n0 -> out[9]=~q_m[8], out[8]=q_m[8], out[7:0]=q_m[8]?q_m:~q_m, cnt += q_m[8]?(n1-n0):(n0-n1).
REQ-017 SHALL, when (cnt>0 and n1>n0) or (cnt<0 and n0>n1), set out[9]=1, invert q_m[7:0], cnt += 2*q_m[8]+n0-n1; otherwise out[9]=0, cnt += -2*~q_m[8]+n1-n0.
REQ-018 SHALL emit control codes 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (bits 9..0) and clear cnt to 0 in control mode.
REQ-019 SHALL treat in_mode=11 as control mode.
REQ-020 SHALL apply mode changes at the symbol boundary; a video symbol following a control symbol starts from cnt=0.
REQ-021 SHALL never let cnt leave [-10,+10]; wrap is a design error.

Reset
REQ-022 SHALL, on areset=1 at a clock edge, clear both stages, set out_parallel=1101010100 (control 00), out_valid=0, cnt=0, regardless of enable.
REQ-023 SHALL discard in-flight symbols when reset asserts mid-pipeline; no out_valid pulse until 2 enabled accepting cycles after release.

Configuration
REQ-024 SHALL, with macro IBIS_TMDS_TERC4_EN defined, encode in_mode=10 via the HDMI 1.4 TERC4 table from in_terc4, clearing cnt.
REQ-025 SHALL, without IBIS_TMDS_TERC4_EN, treat in_mode=10 as control mode, ignore in_terc4, and omit TERC4 logic.

Verification
REQ-026 Reset then video 0x00 twice, back-to-back -> out_parallel 0x100 then 0x3FF; cnt -8 then +2.
REQ-027 Control in_ctrl=01 after video with nonzero cnt -> out_parallel 0010101011; next video 0x00 -> 0x100 (cnt restarted at 0).
REQ-028 TERC4_EN defined, in_mode=10, in_terc4=0000 -> 1010011100; undefined -> 1101010100 when in_ctrl=00.
REQ-029 Accept symbol, drop enable for 3 cycles, re-raise -> out_valid and out_parallel update on 2nd enabled cycle after acceptance; no change while enable=0.
REQ-030 Random video bytes 10k symbols -> output matches reference DVI model bit-exactly; cnt stays within [-10,+10]; areset mid-stream -> control-00 word, no spurious out_valid.
